muldiv_seq_unit: RTL
====================

# muldiv_seq_unit

Multi-cycle RV32M arithmetic unit on the responder side of the execute stage's `start_i`/`busy_o` handshake. It latches operands on a start request and performs the selected MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation iteratively. While working it holds `busy_o` high so the pipeline stalls. It drops `busy_o` for exactly one cycle, in which `c_o` carries the result that the execute stage registers into the memory stage.

## Interface
- `DATA_WIDTH`, default 32: operand/result width (`DATA_WIDTH` from `defines.vh`).
- `clk  in  1`: core clock.
- `rst_n  in  1`: reset, synchronous, active-low.
- `start_i  in  1`: start request; execute stage drives op-is-M & !(busy registered last cycle).
- `funct3_i  in  3`: RV32M funct3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i  in  DATA_WIDTH`: operand A (multiplicand/dividend).
- `rs2_i  in  DATA_WIDTH`: operand B (multiplier/divisor).
- `c_o  out  DATA_WIDTH`: result register; valid in DONE, held afterwards.
- `busy_o  out  1`: stall request; combinational.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start_i`=1 → latch funct3 and operands, set `busy_o`=1 in the same cycle, go to RUN.
  - Special divide cases go directly to DONE instead of RUN (see below).
- RUN: one iteration per cycle; 5-bit counter from 31 down to 0; at 0 → DONE.
- DONE: `busy_o`=0, `c_o` final; unconditionally → IDLE next cycle. `start_i` is ignored in DONE.
- `busy_o` = rst_n & ((IDLE & start_i) | RUN).
- `start_i` and input changes during RUN/DONE are ignored; operands are used only as latched.
- Multiply, shift-add:
  - Operands are extended to 33 bits: signed for MULH both, rs1 only for MULHSU, none for MULHU/MUL.
  - Magnitudes are multiplied; the 64-bit product is negated when the sign bits differ.
  - MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Divide, restoring, on magnitudes:
  - DIV/REM take the absolute values of signed operands.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Special cases, decided in the start cycle with no iterations:
  - B=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - DIV with A=0x80000000, B=0xFFFFFFFF → 0x80000000; the matching REM → 0.
- Reset (any state, including mid-RUN) → IDLE, `c_o`=0, counter=0, `busy_o`=0.

## Timing
- T0 = cycle with IDLE & `start_i`.
- Iterative op: `busy_o` high T0..T32 (33 cycles); DONE at T33 with `c_o` valid; IDLE at T34.
- Special divide case: `busy_o` high at T0 only; DONE at T1.
- Back-to-back M ops: the execute stage's registered-busy gating keeps `start_i` low in DONE. The next start is accepted at the earliest one cycle after DONE.
- `c_o` reset value 0; `c_o` changes only on the DONE transition.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiplies use a single combinational 33x33 signed product registered at T0.
  - `busy_o` high at T0 only; DONE at T1.
  - Divides are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all multiplies use the 32-iteration shift-add path with the timing above.
- Results are bit-identical in both builds.

## Structure
- `defines.vh` holds: funct3 codes (`MULDIV_MUL` .. `MULDIV_REMU`), state encoding (`MULDIV_IDLE/RUN/DONE`), iteration count constant, `DATA_WIDTH`.
- Sub-module `muldiv_div_step`: one combinational restoring-division step. Inputs are partial remainder, quotient, divisor; outputs are the next remainder and quotient.
- The multiply step stays inline.

## Test plan
- MUL 7 × (−3) (0x00000007, 0xFFFFFFFD) → `c_o`=0xFFFFFFEB at T33; `busy_o` high exactly T0..T32.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with DONE at T1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 with DONE at T1.
- `rst_n`=0 at T10 of a DIV → next cycle IDLE, `c_o`=0, `busy_o`=0. A new MUL 3×4 started afterwards → 12 at T33.
- `MULDIV_FAST_MUL_EN` build: MUL 3×4 → 12 with DONE at T1. Inputs toggled during RUN of a DIVU 100/7 → result still 14.

Source files
------------

// File: rtl/muldiv_seq_unit_pkg.sv
// Shared definitions for muldiv_seq_unit: RV32M funct3 codes, FSM state encoding, default width.
package muldiv_seq_unit_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MULDIV_IDLE = 2'd0,
    MULDIV_RUN  = 2'd1,
    MULDIV_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the remainder and emits one quotient bit.
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  assign w_shift = {i_rem, i_quo[W-1]};
  // i_rem < i_div keeps the difference below 2^W, so bit W is a clean borrow flag.
  assign w_diff  = w_shift - {1'b0, i_div};

  assign o_rem = w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
  assign o_quo = {i_quo[W-2:0], ~w_diff[W]};

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M multiply/divide unit: 32 cycles per op, busy_o stalls the pipe, c_o valid in DONE.
// Defining MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-cycle product.
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic [DATA_WIDTH-1:0] c_o,
  output logic                  busy_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  muldiv_state_e   r_state;
  muldiv_state_e   w_state_nxt;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_b;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic            w_is_div;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [W-1:0]    w_special_res;
  logic            w_fast_mul;

  always_comb begin
    w_a_sgn = 1'b0;
    w_b_sgn = 1'b0;
    case (funct3_i)
      MULDIV_MULH, MULDIV_DIV, MULDIV_REM: begin
        w_a_sgn = 1'b1;
        w_b_sgn = 1'b1;
      end
      MULDIV_MULHSU: w_a_sgn = 1'b1;
      MULDIV_MUL, MULDIV_MULHU, MULDIV_DIVU, MULDIV_REMU: begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
      end
      default: begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
      end
    endcase
  end

  assign w_a_neg  = w_a_sgn & rs1_i[W-1];
  assign w_b_neg  = w_b_sgn & rs2_i[W-1];
  assign w_a_mag  = w_a_neg ? -rs1_i : rs1_i;
  assign w_b_mag  = w_b_neg ? -rs2_i : rs2_i;
  assign w_is_div = funct3_i[2];
  assign w_b_zero = (rs2_i == '0);
  assign w_ovf    = (funct3_i == MULDIV_DIV || funct3_i == MULDIV_REM)
                  && (rs1_i == {1'b1, {(W-1){1'b0}}}) && (rs2_i == '1);
  assign w_special = w_is_div & (w_b_zero | w_ovf);

  // funct3[1] separates REM/REMU from DIV/DIVU in both corner cases.
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = funct3_i[1] ? rs1_i : '1;
    else          w_special_res = funct3_i[1] ? '0 : rs1_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*W-1:0] w_fast_prod;
  logic [W-1:0]          w_fast_res;

  assign w_fast_prod = $signed({{W{w_a_neg}}, rs1_i}) * $signed({{W{w_b_neg}}, rs2_i});
  assign w_fast_res  = (funct3_i[1:0] == 2'b00) ? w_fast_prod[W-1:0] : w_fast_prod[2*W-1:W];
  assign w_fast_mul  = ~funct3_i[2];
`else
  assign w_fast_mul  = 1'b0;
`endif

  // Multiply: r_acc = {partial high, multiplier being shifted out}; r_b holds the multiplicand.
  logic [W:0]     w_mul_hi;
  logic [2*W-1:0] w_mul_nxt;
  logic [W-1:0]   w_div_rem;
  logic [W-1:0]   w_div_quo;
  logic [2*W-1:0] w_acc_nxt;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_run_res;

  assign w_mul_hi  = r_acc[0] ? ({1'b0, r_acc[2*W-1:W]} + {1'b0, r_b}) : {1'b0, r_acc[2*W-1:W]};
  assign w_mul_nxt = {w_mul_hi, r_acc[W-1:1]};

  muldiv_div_step #(.W(W)) u_div_step (
    .i_rem (r_acc[2*W-1:W]),
    .i_quo (r_acc[W-1:0]),
    .i_div (r_b),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  assign w_acc_nxt = r_op[2] ? {w_div_rem, w_div_quo} : w_mul_nxt;
  assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    w_run_res = '0;
    if (r_op[2]) begin
      if (r_op[1]) w_run_res = r_neg_r ? -w_div_rem : w_div_rem;
      else         w_run_res = r_neg_q ? -w_div_quo : w_div_quo;
    end else begin
      w_run_res = (r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= MULDIV_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    case (r_state)
      MULDIV_IDLE: begin
        if (start_i) begin
          busy_o      = 1'b1;
          w_state_nxt = (w_special || w_fast_mul) ? MULDIV_DONE : MULDIV_RUN;
        end
      end
      MULDIV_RUN: begin
        busy_o = 1'b1;
        if (r_cnt == '0) w_state_nxt = MULDIV_DONE;
      end
      MULDIV_DONE: w_state_nxt = MULDIV_IDLE;
      default:     w_state_nxt = MULDIV_IDLE;
    endcase
    if (!rst_n) busy_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_o     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        MULDIV_IDLE: begin
          if (start_i) begin
            r_op    <= funct3_i;
            r_cnt   <= CW'(W - 1);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_is_div) begin
              r_acc <= {{W{1'b0}}, w_a_mag};
              r_b   <= w_b_mag;
            end else begin
              r_acc <= {{W{1'b0}}, w_b_mag};
              r_b   <= w_a_mag;
            end
            if (w_special) c_o <= w_special_res;
`ifdef MULDIV_FAST_MUL_EN
            else if (w_fast_mul) c_o <= w_fast_res;
`endif
          end
        end
        MULDIV_RUN: begin
          r_acc <= w_acc_nxt;
          if (r_cnt == '0) c_o   <= w_run_res;
          else             r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
